uart_tx_fifo: RTL and testbench

Byte-wide UART transmitter attached to rbus slave port 3 (address head 8'h02). It captures each byte the core writes through the bus, buffers it in a small FIFO, and serialises it onto a single TX line as 8N1 frames (optionally 8E1). The port is write-only because rbus returns zero for slave-3 reads, so status is exported as sideband outputs for the SoC top level.

---
 rtl/uart_tx_fifo_pkg.sv | 19 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the byte-wide UART transmitter: FSM encodings and rbus slave-3 address head.
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        UTX_IDLE   = 3'd0,
        UTX_START  = 3'd1,
        UTX_DATA   = 3'd2,
        UTX_PARITY = 3'd3,
        UTX_STOP   = 3'd4
    } utx_state_t;

    localparam logic [7:0] UTX_ADDR_HEAD = 8'h02;
    localparam int         UTX_DATA_BITS = 8;

    function automatic logic utx_even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; dout always shows the head entry so a pop can consume it in the same cycle.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [width-1:0]       din,
    output logic [width-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int PTR_W = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is still accepted when a pop frees the head slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == (PTR_W + 1)'(depth));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter on rbus slave 3; define UART_TX_PARITY_EN for 8E1 frames.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic                        we_i,
    input  logic [7:0]                  data_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        ovf_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    utx_state_t  state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [2:0]  bit_idx_inc;
    logic [7:0]  shift_reg, shift_next;
    logic        tx_reg, tx_next;
    logic        ovf_reg;
    logic        bit_end;
    logic        push;
    logic        pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign push = en_i && we_i;

    sync_fifo #(
        .width (UTX_DATA_BITS),
        .depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end     = (baud_reg == BAUD_LAST);
    assign bit_idx_inc = bit_idx_reg + 3'd1;

    always_comb begin
        state_next   = state_reg;
        baud_next    = bit_end ? '0 : baud_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        case (state_reg)
            UTX_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    state_next = UTX_START;
                    tx_next    = 1'b0;
                end
            end
            UTX_START: begin
                if (bit_end) begin
                    state_next   = UTX_DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end
            end
            UTX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = UTX_PARITY;
                        tx_next    = utx_even_parity(shift_reg);
`else
                        state_next = UTX_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = shift_reg[bit_idx_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UTX_PARITY: begin
                if (bit_end) begin
                    state_next = UTX_STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            UTX_STOP: begin
                // Chain straight into the next start bit so back-to-back frames have no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_dout;
                        state_next = UTX_START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = UTX_IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = UTX_IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg   <= UTX_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'd0;
            tx_reg      <= 1'b1;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            if (push && fifo_full && !pop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign tx_o    = tx_reg;
    assign busy_o  = (state_reg != UTX_IDLE);
    assign empty_o = fifo_empty;
    assign full_o  = fifo_full;
    assign ovf_o   = ovf_reg;
    assign count_o = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level queue model checked every cycle, plus directed literal checks.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic       we   = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, busy, empty, full, ovf;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .we_i    (we),
        .data_i  (data),
        .tx_o    (tx),
        .busy_o  (busy),
        .empty_o (empty),
        .full_o  (full),
        .ovf_o   (ovf),
        .count_o (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending bytes and a frame in flight indexed by cycle position.
    logic [7:0] q[$];
    bit         m_active = 0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_ovf    = 0;

    function automatic bit frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic model_step();
        int old_size;
        bit do_pop;
        if (!rst) begin
            q.delete();
            m_active = 0;
            m_pos    = 0;
            m_ovf    = 0;
            return;
        end
        old_size = q.size();
        do_pop   = 0;
        if (!m_active) begin
            do_pop = (old_size > 0);
        end else if (m_pos == FRAME - 1) begin
            if (old_size > 0) do_pop = 1;
            else m_active = 0;
        end else begin
            m_pos++;
        end
        if (do_pop) begin
            m_byte   = q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end
        if (en && we) begin
            if (old_size < DEPTH || do_pop) q.push_back(data);
            else m_ovf = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("model_tx",    tx,    m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1);
            chk("model_busy",  busy,  m_active);
            chk("model_count", count, q.size());
            chk("model_empty", empty, q.size() == 0);
            chk("model_full",  full,  q.size() == DEPTH);
            chk("model_ovf",   ovf,   m_ovf);
        end
    end

    task automatic write_byte(input logic [7:0] b);
        en   = 1'b1;
        we   = 1'b1;
        data = b;
        @(negedge clk);
        en   = 1'b0;
        we   = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'hA5;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count", count, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte A5: start bit on the second edge after the write, LSB first.
        write_byte(pat);
        chk("a5_count_after_push", count, 1);
        chk("a5_tx_idle_after_push", tx, 1);
        @(negedge clk);
        chk("a5_start_tx", tx, 0);
        chk("a5_start_busy", busy, 1);
        chk("a5_start_count", count, 0);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            chk("a5_data_bit", tx, pat[b]);
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("a5_parity_bit", tx, 0);
`endif
        repeat (CPB) @(negedge clk);
        chk("a5_stop_bit", tx, 1);
        chk("a5_stop_busy", busy, 1);
        repeat (CPB) @(negedge clk);
        chk("a5_done_busy", busy, 0);
        chk("a5_done_tx", tx, 1);

        // A read strobe must not enqueue anything.
        en = 1'b1; we = 1'b0; data = 8'h3C;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("read_ignored_count", count, 0);
        chk("read_ignored_busy", busy, 0);

        // Back-to-back frames.
        write_byte(8'h55);
        write_byte(8'h0F);
        repeat (2 * FRAME + 4) @(negedge clk);
        chk("b2b_done_busy", busy, 0);

        // Overflow: six consecutive writes while idle.
        for (int i = 1; i <= 6; i++) write_byte(8'(i));
        chk("ovf_count_full", count, 4);
        chk("ovf_set", ovf, 1);
        repeat (6 * FRAME) @(negedge clk);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_drained_busy", busy, 0);

        // Reset during data bit 3 of a frame.
        write_byte(8'hC3);
        write_byte(8'h81);
        repeat (1 + 4 * CPB) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_count", count, 0);
        chk("midrst_ovf", ovf, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle_busy", busy, 0);

        // Push in the same cycle as the STOP-to-START pop with the FIFO full.
        for (int i = 0; i < 5; i++) write_byte(8'h10 + 8'(i));
        chk("pp_full_before", count, 4);
        repeat (FRAME - 4) @(negedge clk);
        write_byte(8'hEE);
        chk("pp_count_stays", count, 4);
        chk("pp_no_ovf", ovf, 0);
        repeat (6 * FRAME) @(negedge clk);

        // Randomised traffic with varying write density and occasional resets.
        for (int phase = 0; phase < 4; phase++) begin
            int pct;
            pct = (phase == 0) ? 3 : (phase == 1) ? 20 : (phase == 2) ? 60 : 8;
            for (int c = 0; c < 1500; c++) begin
                en   = ($urandom_range(0, 99) < pct);
                we   = ($urandom_range(0, 9) != 0);
                data = 8'($urandom);
                rst  = ($urandom_range(0, 799) != 0);
                @(negedge clk);
            end
        end
        en = 1'b0; we = 1'b0; rst = 1'b1;
        repeat ((DEPTH + 1) * FRAME + 4) @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("final_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
